// File: rtl/pxie_c2h_req_sched.sv
// pxie_c2h_req_sched: queued C2H read-request scheduler with completion tracking and guard gap.
// Optional feature: define C2H_SCHED_TIMEOUT_EN to enable the WAIT-state timeout (err_timeout).
module pxie_c2h_req_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        c2h_clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_len,
    output logic [15:0] c2h_addr,
    output logic [15:0] c2h_len,
    output logic        c2h_en,
    input  logic        c2h_tvalid,
    input  logic        c2h_tready,
    input  logic        c2h_tlast,
    output logic        busy,
    output logic        done_pulse,
    output logic [15:0] done_cnt,
    output logic        err_req,
    output logic        err_beat,
    output logic        err_timeout
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_CYCLES < 1
        || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_param_chk
        $error("pxie_c2h_req_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t        r_state;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          r_stg_vld;
    logic [31:0]   r_stg_req;
    logic          r_launch;
    logic [31:0]   r_head;
    logic [15:0]   r_beat_cnt;
    logic [GW-1:0] r_gap_cnt;
`ifdef C2H_SCHED_TIMEOUT_EN
    logic [15:0]   r_wait_cnt;
`endif

    logic [PW:0]   w_fifo_cnt;
    logic [PW+1:0] w_occ;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_bad;
    logic          w_pop;
    logic          w_beat;
    logic [16:0]   w_end;
    logic [16:0]   w_beat_inc;

    // The validation stage counts toward occupancy so an accepted request always finds a slot.
    assign w_fifo_cnt = r_wr_ptr - r_rd_ptr;
    assign w_occ      = {1'b0, w_fifo_cnt} + {{(PW + 1){1'b0}}, r_stg_vld};
    assign w_full     = (w_occ >= (PW + 2)'(FIFO_DEPTH));
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign req_ready  = !w_full;

    assign w_push     = req_valid && req_ready;
    assign w_end      = {1'b0, req_addr} + {1'b0, req_len};
    assign w_bad      = (req_len == 16'd0) || req_len[0] || (w_end > 17'h10000);
    assign w_pop      = (r_state == S_IDLE) && !r_launch && !w_empty;
    assign w_beat     = c2h_tvalid && c2h_tready;
    assign w_beat_inc = {1'b0, r_beat_cnt} + 17'd1;
    assign busy       = (r_state != S_IDLE) || !w_empty || r_stg_vld || r_launch;

    // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge c2h_clk) begin
        if (r_stg_vld) begin
            r_mem[r_wr_ptr[PW-1:0]] <= r_stg_req;
        end
    end

    // NOTE: non-blocking assignments keep every register update independent of statement order.
    always_ff @(posedge c2h_clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_stg_vld <= 1'b0;
            r_stg_req <= '0;
        end else begin
            r_stg_vld <= w_push && !w_bad;
            if (w_push) begin
                r_stg_req <= {req_addr, req_len};
            end
            if (r_stg_vld) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge c2h_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_launch    <= 1'b0;
            r_head      <= '0;
            r_beat_cnt  <= '0;
            r_gap_cnt   <= '0;
            c2h_addr    <= '0;
            c2h_len     <= '0;
            c2h_en      <= 1'b0;
            done_pulse  <= 1'b0;
            done_cnt    <= '0;
            err_req     <= 1'b0;
            err_beat    <= 1'b0;
            err_timeout <= 1'b0;
`ifdef C2H_SCHED_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            c2h_en      <= 1'b0;
            done_pulse  <= 1'b0;
            err_beat    <= 1'b0;
            err_timeout <= 1'b0;
            err_req     <= w_push && w_bad;

            case (r_state)
                S_IDLE: begin
                    // Head is popped one cycle, then presented to the TX stage the next.
                    if (r_launch) begin
                        c2h_addr <= r_head[31:16];
                        c2h_len  <= r_head[15:0];
                        c2h_en   <= 1'b1;
                        r_launch <= 1'b0;
                        r_state  <= S_ISSUE;
                    end else if (w_pop) begin
                        r_head   <= r_mem[r_rd_ptr[PW-1:0]];
                        r_launch <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_beat_cnt <= '0;
`ifdef C2H_SCHED_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_beat) begin
                        if (r_beat_cnt != 16'hFFFF) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
`ifdef C2H_SCHED_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                        if (c2h_tlast) begin
                            done_pulse <= 1'b1;
                            done_cnt   <= done_cnt + 1'b1;
                            err_beat   <= (w_beat_inc != {2'b00, c2h_len[15:1]});
                            r_gap_cnt  <= '0;
                            r_state    <= S_GAP;
                        end
                    end
`ifdef C2H_SCHED_TIMEOUT_EN
                    else if (r_wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pxie_c2h_req_sched.sv
// tb_pxie_c2h_req_sched: directed + randomized bench with a queue-based reference model.
// Exercises the timeout path only when C2H_SCHED_TIMEOUT_EN is defined.
module tb_pxie_c2h_req_sched;
    localparam int DEPTH = 4;
    localparam int GAP   = 16;
    localparam int TO    = 100;

    logic        c2h_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic [15:0] c2h_addr;
    logic [15:0] c2h_len;
    logic        c2h_en;
    logic        c2h_tvalid = 1'b0;
    logic        c2h_tready = 1'b0;
    logic        c2h_tlast = 1'b0;
    logic        busy;
    logic        done_pulse;
    logic [15:0] done_cnt;
    logic        err_req;
    logic        err_beat;
    logic        err_timeout;

    always #5 c2h_clk = ~c2h_clk;

    pxie_c2h_req_sched #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP),
        .TIMEOUT_CYC(TO)
    ) dut (
        .c2h_clk    (c2h_clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .c2h_addr   (c2h_addr),
        .c2h_len    (c2h_len),
        .c2h_en     (c2h_en),
        .c2h_tvalid (c2h_tvalid),
        .c2h_tready (c2h_tready),
        .c2h_tlast  (c2h_tlast),
        .busy       (busy),
        .done_pulse (done_pulse),
        .done_cnt   (done_cnt),
        .err_req    (err_req),
        .err_beat   (err_beat),
        .err_timeout(err_timeout)
    );

    typedef struct { logic [15:0] addr; logic [15:0] len; int at; } issue_t;
    typedef struct { logic [15:0] addr; logic [15:0] len; } req_t;

    int     cyc = 0;
    issue_t obs_q[$];
    req_t   exp_q[$];
    int     n_done = 0, n_err_req = 0, n_err_beat = 0, n_err_to = 0, to_at = 0;
    int     m_done = 0, m_done_all = 0, m_err_req = 0, m_err_beat = 0;
    int     last_en_at = -1000;
    int     n_pass = 0, n_fail = 0, n_total = 0;

    always @(posedge c2h_clk) cyc <= cyc + 1;

    // Event monitor: records every issue and counts every pulse, mid-cycle.
    always @(negedge c2h_clk) begin
        if (c2h_en) obs_q.push_back('{c2h_addr, c2h_len, cyc});
        if (done_pulse) n_done++;
        if (err_req) n_err_req++;
        if (err_beat) n_err_beat++;
        if (err_timeout) begin
            n_err_to++;
            to_at = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge c2h_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] l);
        bit bad;
        int g;
        bad = (l == 16'd0) || (l % 2 != 0) || (int'(a) + int'(l) > 65536);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        g = 0;
        while (req_ready !== 1'b1 && g < 2000) begin
            tick();
            g++;
        end
        if (req_ready !== 1'b1) begin
            check("push_ready_wait", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        check("err_req_after_push", err_req, bad);
        if (bad) m_err_req++;
        else exp_q.push_back('{a, l});
    endtask

    task automatic wait_issue(output issue_t o, output bit ok);
        int g;
        g = 0;
        ok = 1'b0;
        while (obs_q.size() == 0 && g < 500) begin
            tick();
            g++;
        end
        check("issue_seen", obs_q.size() > 0, 1);
        if (obs_q.size() == 0) return;
        o = obs_q.pop_front();
        check("issue_expected", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        ok = 1'b1;
    endtask

    task automatic service(input int beats);
        issue_t o;
        req_t   e;
        bit     ok;
        int     st;
        wait_issue(o, ok);
        if (!ok) return;
        e = exp_q.pop_front();
        check("issue_addr", o.addr, e.addr);
        check("issue_len", o.len, e.len);
        if (last_en_at >= 0) check("en_spacing_ge_gap3", (o.at - last_en_at) >= GAP + 3, 1);
        last_en_at = o.at;
        while (cyc <= o.at) tick();
        for (int i = 0; i < beats; i++) begin
            st = $urandom_range(0, 2);
            for (int s = 0; s < st; s++) begin
                c2h_tvalid = 1'($urandom_range(0, 1));
                c2h_tready = !c2h_tvalid;
                c2h_tlast  = 1'($urandom_range(0, 1));
                tick();
            end
            c2h_tvalid = 1'b1;
            c2h_tready = 1'b1;
            c2h_tlast  = (i == beats - 1);
            tick();
        end
        m_done++;
        m_done_all++;
        check("done_pulse", done_pulse, 1);
        check("err_beat", err_beat, beats != int'(e.len) / 2);
        if (beats != int'(e.len) / 2) m_err_beat++;
        check("done_cnt", done_cnt, 16'(m_done));
        for (int i = 0; i < 4; i++) begin
            c2h_tvalid = 1'($urandom_range(0, 1));
            c2h_tready = 1'b1;
            c2h_tlast  = 1'($urandom_range(0, 1));
            tick();
        end
        c2h_tvalid = 1'b0;
        c2h_tready = 1'b0;
        c2h_tlast  = 1'b0;
        check("done_cnt_gap_ignored", done_cnt, 16'(m_done));
        check("c2h_addr_hold", c2h_addr, e.addr);
        check("c2h_len_hold", c2h_len, e.len);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 300) begin
            tick();
            g++;
        end
        check("idle", busy, 0);
    endtask

    initial begin
        issue_t o;
        bit     ok;
        int     p, snap;

        // Reset state
        tick(3);
        check("rst_c2h_addr", c2h_addr, 0);
        check("rst_c2h_len", c2h_len, 0);
        check("rst_c2h_en", c2h_en, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_done_cnt", done_cnt, 0);
        rstn = 1'b1;
        tick();
        check("post_rst_errs", {done_pulse, err_req, err_beat, err_timeout}, 0);

        // Single transfer, issue latency
        push(16'h0100, 16'd8);
        p = cyc;
        wait_issue(o, ok);
        if (ok) begin
            check("latency_3", o.at - p, 3);
            obs_q.push_front(o);
        end
        service(4);
        wait_idle();
        check("t1_no_extra_issue", obs_q.size(), 0);

        // Rejected requests
        snap = n_err_req;
        push(16'h0000, 16'd0);
        push(16'h0000, 16'd7);
        push(16'hFFF0, 16'h0020);
        tick(10);
        check("t2_err_req_pulses", n_err_req - snap, 3);
        check("t2_no_issue", obs_q.size(), 0);
        check("t2_busy", busy, 0);

        // Queue fill and in-order drain
        push(16'h0200, 16'd2);
        push(16'h0300, 16'd4);
        push(16'h0400, 16'd6);
        push(16'h0500, 16'd8);
        push(16'h0600, 16'd10);
        tick();
        check("t3_full_ready", req_ready, 0);
        check("t3_one_issued", obs_q.size(), 1);
        req_valid = 1'b1;
        req_addr  = 16'h0700;
        req_len   = 16'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_full_hold", req_ready, 0);
        end
        req_valid = 1'b0;
        for (int i = 1; i <= 5; i++) service(i);
        wait_idle();
        check("t3_no_extra_issue", obs_q.size(), 0);

        // Short transfer and exact address-space boundary
        push(16'h0A00, 16'd8);
        service(3);
        push(16'hFFF0, 16'h0010);
        service(8);
        wait_idle();

`ifdef C2H_SCHED_TIMEOUT_EN
        push(16'h0800, 16'd4);
        push(16'h0900, 16'd2);
        snap = n_err_to;
        wait_issue(o, ok);
        if (ok) begin
            void'(exp_q.pop_front());
            p = 0;
            while (n_err_to == snap && p < 400) begin
                tick();
                p++;
            end
            check("to_pulse_seen", n_err_to - snap, 1);
            check("to_cycle", to_at - o.at, TO + 1);
            check("to_done_cnt_kept", done_cnt, 16'(m_done));
            last_en_at = o.at;
        end
        service(1);
        wait_idle();
`endif

        // Reset mid-WAIT with requests queued
        push(16'h1000, 16'd4);
        push(16'h1100, 16'd4);
        push(16'h1200, 16'd4);
        wait_issue(o, ok);
        tick(3);
        snap = n_done + n_err_req + n_err_beat + n_err_to;
        rstn = 1'b0;
        #2;
        check("rstw_outputs", {c2h_addr, c2h_len}, 0);
        check("rstw_pulses", {c2h_en, done_pulse, err_req, err_beat, err_timeout}, 0);
        check("rstw_busy", busy, 0);
        check("rstw_done_cnt", done_cnt, 0);
        check("rstw_ready", req_ready, 1);
        tick(2);
        rstn = 1'b1;
        exp_q.delete();
        obs_q.delete();
        m_done = 0;
        last_en_at = -1000;
        tick(25);
        check("rstw_no_issue_after", obs_q.size(), 0);
        check("rstw_no_pulses", n_done + n_err_req + n_err_beat + n_err_to, snap);
        push(16'h1234, 16'd4);
        service(2);
        wait_idle();

        // Randomized requests against the model
        for (int it = 0; it < 24; it++) begin
            int kind, len, addr, beats;
            kind = $urandom_range(0, 7);
            len  = 2 * $urandom_range(1, 8);
            case (kind)
                0: begin len = 0; addr = $urandom_range(0, 65535); end
                1: begin len = len - 1; addr = $urandom_range(0, 1000); end
                2: addr = 65536 - len + $urandom_range(1, len - 1);
                3: addr = 65536 - len;
                default: addr = $urandom_range(0, 65536 - len);
            endcase
            push(16'(addr), 16'(len));
            if (len != 0 && len % 2 == 0 && addr + len <= 65536) begin
                beats = len / 2;
                if ($urandom_range(0, 3) == 0) beats = ($urandom_range(0, 1) != 0) ? beats + 1 : beats - 1;
                if (beats < 1) beats = 2;
                service(beats);
            end
        end
        wait_idle();

        check("final_obs_empty", obs_q.size(), 0);
        check("final_exp_empty", exp_q.size(), 0);
        check("final_err_req", n_err_req, m_err_req);
        check("final_err_beat", n_err_beat, m_err_beat);
        check("final_done_pulses", n_done, m_done_all);
        check("final_done_cnt", done_cnt, 16'(m_done));
`ifdef C2H_SCHED_TIMEOUT_EN
        check("final_err_timeout", n_err_to, 1);
`else
        check("final_err_timeout", n_err_to, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
